// File: rtl/irda_pkg.sv
// Shared IrDA SIR definitions: decoder FSM states and default timing constants,
// common to the SIR decoder and the receiver controller.
package irda_pkg;

   localparam int unsigned IRDA_CLKS_PER_BIT = 16;
   localparam int unsigned IRDA_MIN_PULSE    = 2;
   localparam int unsigned IRDA_MAX_PULSE    = 8;

   typedef enum logic [1:0] {
      IDLE,
      QUAL,
      HOLD,
      LONG
   } irda_state_e;

endpackage

// File: rtl/irda_sync.sv
// Two-flop synchroniser for the asynchronous IR receiver output.
module irda_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/irda_sir_decoder.sv
// IrDA SIR pulse decoder: turns qualified IR pulses into an NRZ bit stream.
// Optional over-long pulse detection is enabled by defining IRDA_PULSE_ERR_EN.
module irda_sir_decoder
   import irda_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = IRDA_CLKS_PER_BIT,
   parameter int unsigned MIN_PULSE    = IRDA_MIN_PULSE,
   parameter int unsigned MAX_PULSE    = IRDA_MAX_PULSE
) (
   input  logic clk,
   input  logic reset,
   input  logic ir_in,
   output logic data_out,
   output logic pulse_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + MIN_PULSE + 1);
   localparam logic [CW-1:0] MIN_C   = CW'(MIN_PULSE);
   localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] WIN_END = CW'(CLKS_PER_BIT + MIN_PULSE - 1);
`ifdef IRDA_PULSE_ERR_EN
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_PULSE);
`endif

   if (!(MIN_PULSE >= 1 && MIN_PULSE < MAX_PULSE && MAX_PULSE <= CLKS_PER_BIT / 2)) begin : g_bad_params
      $error("irda_sir_decoder: unsupported CLKS_PER_BIT/MIN_PULSE/MAX_PULSE combination");
   end

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   irda_state_e   state, state_next;
   logic          s_in, s_prev, rise;
   logic [CW-1:0] hcnt, hcnt_next;
   logic [CW-1:0] win, win_next;
   logic [CW-1:0] hwin, hwin_next;
   logic          retrig, retrig_next;
   logic          dout_next;
   logic          hcnt_qual, win_done, hwin_done, edge_ok, too_long;

   irda_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ir_in),
      .q     (s_in)
   );

   assign rise      = s_in & ~s_prev;
   assign hcnt_qual = sat_inc(hcnt) >= MIN_C;
   assign win_done  = sat_inc(win) >= WIN_END;
   assign hwin_done = sat_inc(hwin) >= WIN_END;
   assign edge_ok   = rise && (win >= HALF_C);
`ifdef IRDA_PULSE_ERR_EN
   assign too_long  = s_in && (sat_inc(hcnt) > MAX_C);
`else
   assign too_long  = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         s_prev   <= 1'b0;
         hcnt     <= '0;
         win      <= '0;
         hwin     <= '0;
         retrig   <= 1'b0;
         data_out <= 1'b1;
      end else begin
         state    <= state_next;
         s_prev   <= s_in;
         hcnt     <= hcnt_next;
         win      <= win_next;
         hwin     <= hwin_next;
         retrig   <= retrig_next;
         data_out <= dout_next;
      end
   end

   // A glitch that re-entered QUAL from HOLD returns to HOLD so the running bit
   // window is not cut short; only a glitch seen from IDLE falls back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (s_in) state_next = QUAL;
         QUAL: begin
            if (too_long)                 state_next = LONG;
            else if (s_in)                state_next = hcnt_qual ? HOLD : QUAL;
            else if (retrig && !hwin_done) state_next = HOLD;
            else                          state_next = IDLE;
         end
         HOLD: begin
            if (too_long)      state_next = LONG;
            else if (edge_ok)  state_next = QUAL;
            else if (win_done) state_next = IDLE;
         end
         LONG: if (!s_in) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef IRDA_PULSE_ERR_EN
   logic perr_next;
`endif

   // hwin shadows the HOLD window while a retrigger is being qualified.
   always_comb begin
      hcnt_next   = s_in ? sat_inc(hcnt) : '0;
      win_next    = win;
      hwin_next   = hwin;
      retrig_next = retrig;
      dout_next   = data_out;
`ifdef IRDA_PULSE_ERR_EN
      perr_next   = 1'b0;
`endif
      case (state_next)
         IDLE: begin
            dout_next   = 1'b1;
            hcnt_next   = '0;
            win_next    = '0;
            retrig_next = 1'b0;
         end
         QUAL: begin
            if (state != QUAL) begin
               hcnt_next   = CW'(1);
               win_next    = '0;
               hwin_next   = sat_inc(win);
               retrig_next = (state == HOLD);
            end else begin
               win_next  = sat_inc(win);
               hwin_next = sat_inc(hwin);
            end
         end
         HOLD: begin
            dout_next = 1'b0;
            win_next  = (state == QUAL && !s_in) ? sat_inc(hwin) : sat_inc(win);
         end
         LONG: begin
            dout_next = 1'b1;
`ifdef IRDA_PULSE_ERR_EN
            perr_next = (state != LONG);
`endif
         end
         default: dout_next = 1'b1;
      endcase
   end

`ifdef IRDA_PULSE_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pulse_err <= 1'b0;
      else       pulse_err <= perr_next;
   end
`else
   assign pulse_err = 1'b0;
`endif

endmodule
